mult8x8_seq_ctrl: RTL and testbench

//   Sequencer for the sequential 8x8 unsigned multiplier datapath.
//   - Splits latched operands into nibbles and drives them to the external 4x4 multiplier.
//   - Drives shift_cntrl of the 16-bit shifter (shifter inp = 4x4 product).
//   - Accumulates shifter output over 4 passes and returns the 16-bit product

---
 rtl/mult8x8_seq_ctrl.sv | 103 ++++++++++
 tb/tb_mult8x8_seq_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mult8x8_seq_ctrl.sv
// Sequencer for a sequential 8x8 unsigned multiplier built from an external 4x4 multiplier and shifter.
// Optional build macro MULT_ZERO_SKIP_EN: a zero operand bypasses the four passes and completes at once.
module mult8x8_seq_ctrl #(
  parameter int unsigned DONE_HOLD = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  data_a,
  input  logic [7:0]  data_b,
  output logic [3:0]  mult_a,
  output logic [3:0]  mult_b,
  output logic [1:0]  shift_cntrl,
  input  logic [15:0] shift_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  count;
  logic [15:0] acc;
  logic [7:0]  a_reg, b_reg;
  logic        accept, skip, last_pass;

  // start is only honoured outside CALC; requests during a calculation are dropped.
  assign accept    = start && (state != CALC);
  assign last_pass = (state == CALC) && (count == 2'd3);

`ifdef MULT_ZERO_SKIP_EN
  assign skip = accept && ((data_a == 8'h00) || (data_b == 8'h00));
`else
  assign skip = 1'b0;
`endif

  assign busy = (state == CALC);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, otherwise an unassigned path infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = skip ? DONE : CALC;
        else        state_nxt = IDLE;
      end
      CALC:    if (count == 2'd3) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= 2'd0;
      acc     <= 16'h0000;
      a_reg   <= 8'h00;
      b_reg   <= 8'h00;
      product <= 16'h0000;
      done    <= 1'b0;
    end else begin
      if (accept) begin
        a_reg <= data_a;
        b_reg <= data_b;
        acc   <= 16'h0000;
        count <= 2'd0;
      end else if (state == CALC) begin
        acc   <= acc + shift_out;
        count <= count + 2'd1;
      end

      if (last_pass)  product <= acc + shift_out;
      else if (skip)  product <= 16'h0000;

      // With DONE_HOLD set, done survives IDLE and is only cleared by the next accepted start.
      if (last_pass || skip)              done <= 1'b1;
      else if (accept || DONE_HOLD == 0)  done <= 1'b0;
    end
  end

  // Pass schedule: count[1] picks the A nibble, count[0] the B nibble.
  always_comb begin
    mult_a      = 4'h0;
    mult_b      = 4'h0;
    shift_cntrl = 2'b00;
    if (state == CALC) begin
      mult_a = count[1] ? a_reg[7:4] : a_reg[3:0];
      mult_b = count[0] ? b_reg[7:4] : b_reg[3:0];
      unique case (count)
        2'd0:    shift_cntrl = 2'b00;
        2'd3:    shift_cntrl = 2'b10;
        default: shift_cntrl = 2'b01;
      endcase
    end
  end

endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// Bench for mult8x8_seq_ctrl: models the external 4x4 multiplier and shifter, scoreboards products,
// and checks pass schedule, latency, handshake and reset behaviour.
module tb_mult8x8_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  data_a = 8'h00;
  logic [7:0]  data_b = 8'h00;
  logic [3:0]  mult_a, mult_b;
  logic [1:0]  shift_cntrl;
  logic [15:0] shift_out;
  logic        busy, done;
  logic [15:0] product;

  int          total = 0;
  int          passed = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  cur_a, cur_b;
  logic [7:0]  sh_seq;
  logic [7:0]  nib_prod;

  mult8x8_seq_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .data_a(data_a), .data_b(data_b),
    .mult_a(mult_a), .mult_b(mult_b), .shift_cntrl(shift_cntrl), .shift_out(shift_out),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  // External 4x4 multiplier feeding the 16-bit shifter.
  assign nib_prod  = {4'h0, mult_a} * {4'h0, mult_b};
  assign shift_out = {8'h00, nib_prod} << {shift_cntrl, 2'b00};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [9:0] pass_model(input int p);
    logic [3:0] ma, mb;
    logic [1:0] sc;
    ma = p[1] ? cur_a[7:4] : cur_a[3:0];
    mb = p[0] ? cur_b[7:4] : cur_b[3:0];
    sc = (p == 0) ? 2'b00 : (p == 3) ? 2'b10 : 2'b01;
    return {ma, mb, sc};
  endfunction

  // Called at a negedge; start is sampled at the next posedge (edge T); returns at negedge of cycle T+1.
  task automatic drive_start(input logic [7:0] a, input logic [7:0] b);
    start  = 1'b1;
    data_a = a;
    data_b = b;
    cur_a  = a;
    cur_b  = b;
    exp_q.push_back({8'h00, a} * {8'h00, b});
    @(negedge clk);
    start  = 1'b0;
    data_a = 8'($urandom);
    data_b = 8'($urandom);
  endtask

  // Waits (bounded) for done from cycle T+1; poke > 0 raises an ignored start in that cycle.
  task automatic wait_done(input string tag, input int exp_lat, input int exp_busy, input int poke);
    int          lat = 1;
    int          nbusy = 0;
    logic [15:0] exp_p;
    sh_seq = 8'h00;
    while (!done && lat < 20) begin
      if (busy) begin
        check({tag, "_pass"}, {22'h0, mult_a, mult_b, shift_cntrl}, {22'h0, pass_model(nbusy)});
        sh_seq = {sh_seq[5:0], shift_cntrl};
        nbusy++;
      end
      start = (lat == poke);
      if (lat == poke) begin
        data_a = 8'h02;
        data_b = 8'h03;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, nbusy, exp_busy);
    exp_p = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    check({tag, "_product"}, product, exp_p);
  endtask

  initial begin
    int ndone;

    #2;
    check("reset_outputs", {busy, done, product, mult_a, mult_b, shift_cntrl},
          {1'b0, 1'b0, 16'h0000, 4'h0, 4'h0, 2'b00});
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Max operands.
    drive_start(8'hFF, 8'hFF);
    wait_done("ff_x_ff", 5, 4, 0);
    @(negedge clk);
    check("done_pulse_width", done, 1'b0);
    check("idle_outputs", {busy, mult_a, mult_b, shift_cntrl}, 11'h000);

    // Shift schedule.
    drive_start(8'h12, 8'h34);
    wait_done("12_x_34", 5, 4, 0);
    check("shift_sequence", sh_seq, 8'b00_01_01_10);
    @(negedge clk);

    // Start during CALC is ignored and not queued.
    drive_start(8'h12, 8'h34);
    wait_done("busy_start", 5, 4, 2);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("no_second_done", ndone, 0);

    // Reset mid-calculation abandons the operation.
    drive_start(8'hFF, 8'hFF);
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_count2", shift_cntrl, 2'b01);
    #1 reset_n = 1'b0;
    #1;
    check("async_reset_outputs", {busy, done, product, mult_a, mult_b, shift_cntrl},
          {1'b0, 1'b0, 16'h0000, 4'h0, 4'h0, 2'b00});
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    drive_start(8'h0F, 8'h10);
    wait_done("after_reset", 5, 4, 0);

    // Back-to-back: start held through the DONE cycle.
    @(negedge clk);
    drive_start(8'hA5, 8'h3C);
    wait_done("b2b_first", 5, 4, 0);
    drive_start(8'h03, 8'h05);
    check("b2b_no_bubble", busy, 1'b1);
    wait_done("b2b_second", 5, 4, 0);
    @(negedge clk);

    // Zero operand.
    drive_start(8'h00, 8'h5A);
`ifdef MULT_ZERO_SKIP_EN
    wait_done("zero_a", 1, 0, 0);
`else
    wait_done("zero_a", 5, 4, 0);
`endif
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      drive_start(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
      wait_done("random", 5, 4, 0);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
